// File: rtl/mem_wb_pipe_if.sv
// MEM-to-WB stage bus: MEM-side control/data into the pipe register,
// WB-side fields plus the selected writeback value back out.
interface mem_wb_pipe_if #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
);
    logic              stall;
    logic              flush;
    logic              mem_valid;
    logic              mem_regWrite;
    logic [1:0]        mem_memToReg;
    logic [REG_W-1:0]  mem_write_reg;
    logic [DATA_W-1:0] mem_alu_out;
    logic [DATA_W-1:0] mem_pc_plus;
    logic [DATA_W-1:0] mem_read_data;
    logic [DATA_W-1:0] mem_sign_ext_low_bits;
    logic              wb_valid;
    logic              wb_regWrite;
    logic [1:0]        wb_memToReg;
    logic [REG_W-1:0]  wb_write_reg;
    logic [DATA_W-1:0] wb_alu_out;
    logic [DATA_W-1:0] wb_pc_plus;
    logic [DATA_W-1:0] wb_read_data;
    logic [DATA_W-1:0] wb_sign_ext_low_bits;
    logic [DATA_W-1:0] wb_write_data;
    logic              wb_reg_we;

    modport master (
        output stall, flush, mem_valid, mem_regWrite, mem_memToReg, mem_write_reg,
               mem_alu_out, mem_pc_plus, mem_read_data, mem_sign_ext_low_bits,
        input  wb_valid, wb_regWrite, wb_memToReg, wb_write_reg, wb_alu_out,
               wb_pc_plus, wb_read_data, wb_sign_ext_low_bits, wb_write_data, wb_reg_we
    );

    modport slave (
        input  stall, flush, mem_valid, mem_regWrite, mem_memToReg, mem_write_reg,
               mem_alu_out, mem_pc_plus, mem_read_data, mem_sign_ext_low_bits,
        output wb_valid, wb_regWrite, wb_memToReg, wb_write_reg, wb_alu_out,
               wb_pc_plus, wb_read_data, wb_sign_ext_low_bits, wb_write_data, wb_reg_we
    );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: registered (BYPASS=0) or pass-through (BYPASS=1),
// with writeback-value mux, qualified write enable and a wrapping retire counter.
module mem_wb_pipe #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int BYPASS = 0,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    mem_wb_pipe_if.slave     bus,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [1:0]        mem_to_reg;
        logic [REG_W-1:0]  write_reg;
        logic [DATA_W-1:0] alu_out;
        logic [DATA_W-1:0] pc_plus;
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] sext;
    } stage_t;

    stage_t           mem_s;
    stage_t           wb_s;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Gather the MEM-side fields into one record
    always_comb begin
        mem_s            = '0;
        mem_s.valid      = bus.mem_valid;
        mem_s.reg_write  = bus.mem_regWrite;
        mem_s.mem_to_reg = bus.mem_memToReg;
        mem_s.write_reg  = bus.mem_write_reg;
        mem_s.alu_out    = bus.mem_alu_out;
        mem_s.pc_plus    = bus.mem_pc_plus;
        mem_s.read_data  = bus.mem_read_data;
        mem_s.sext       = bus.mem_sign_ext_low_bits;
    end

    if (BYPASS == 0) begin : g_reg
        stage_t stage_q;
        stage_t stage_d;

        // Next stage contents: flush beats stall beats load
        always_comb begin
            stage_d = stage_q;
            if (bus.flush) begin
                stage_d = '0;
            end else if (bus.stall) begin
                stage_d = stage_q;
            end else begin
                stage_d = mem_s;
            end
        end

        // Stage register
        always_ff @(posedge clk) begin
            if (rst) begin
                stage_q <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end

        // WB side sees only the register, so nothing here depends on stall
        always_comb begin
            wb_s = stage_q;
        end
    end else begin : g_byp
        // Pass-through; flush only cancels the instruction, data still flows
        always_comb begin
            wb_s = mem_s;
            if (bus.flush) begin
                wb_s.valid     = 1'b0;
                wb_s.reg_write = 1'b0;
            end else begin
                wb_s = mem_s;
            end
        end
    end

    // Drive WB-side outputs, writeback mux and qualified write enable
    always_comb begin
        bus.wb_valid             = wb_s.valid;
        bus.wb_regWrite          = wb_s.reg_write;
        bus.wb_memToReg          = wb_s.mem_to_reg;
        bus.wb_write_reg         = wb_s.write_reg;
        bus.wb_alu_out           = wb_s.alu_out;
        bus.wb_pc_plus           = wb_s.pc_plus;
        bus.wb_read_data         = wb_s.read_data;
        bus.wb_sign_ext_low_bits = wb_s.sext;
        bus.wb_reg_we            = wb_s.valid & wb_s.reg_write;
        case (wb_s.mem_to_reg)
            2'd0:    bus.wb_write_data = wb_s.alu_out;
            2'd1:    bus.wb_write_data = wb_s.read_data;
            2'd2:    bus.wb_write_data = wb_s.pc_plus;
            2'd3:    bus.wb_write_data = wb_s.sext;
            default: bus.wb_write_data = wb_s.alu_out;
        endcase
    end

    // An instruction retires when it leaves WB unstalled
    always_comb begin
        if (wb_s.valid && !bus.stall) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Retire counter register, wraps freely
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign retire_cnt = cnt_q;

endmodule

// File: doc/mem_wb_pipe.md
MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the width of all data fields (alu_out, pc_plus, read_data, sign_ext_low_bits, write_data).
REQ-002 Parameter REG_W, default 3, SHALL set the destination register address width.
REQ-003 Parameter BYPASS, default 0, SHALL select the mode: 0 = registered stage, 1 = combinational pass-through.
REQ-004 Parameter CNT_W, default 16, SHALL set the retire counter width.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 stall  in  1  hold the stage contents this cycle.
REQ-008 flush  in  1  replace the stage contents with a bubble this cycle.
REQ-009 mem_valid  in  1  the MEM-side instruction is real (not a bubble).
REQ-010 mem_regWrite  in  1; mem_memToReg  in  2; mem_write_reg  in  REG_W: MEM-side control fields.
REQ-011 mem_alu_out, mem_pc_plus, mem_read_data, mem_sign_ext_low_bits  in  DATA_W each: MEM-side data fields.
REQ-012 wb_valid  out  1; wb_regWrite  out  1; wb_memToReg  out  2; wb_write_reg  out  REG_W: WB-side control fields.
REQ-013 wb_alu_out, wb_pc_plus, wb_read_data, wb_sign_ext_low_bits  out  DATA_W each: WB-side data fields.
REQ-014 wb_write_data  out  DATA_W: selected writeback value.
REQ-015 wb_reg_we  out  1: qualified register-file write enable.
REQ-016 retire_cnt  out  CNT_W: count of retired valid instructions.

Function
REQ-017 With BYPASS=0, all wb_* fields, including wb_valid, SHALL be registered with a latency of one cycle from the mem_* inputs.
REQ-018 With BYPASS=0, the rising-edge update priority SHALL be: rst, then flush, then stall, then load.
REQ-019 On load (no rst, flush or stall), every wb_* register SHALL take the corresponding mem_* value.
REQ-020 On stall without flush, every wb_* register SHALL hold its value.
REQ-021 On flush, wb_valid and wb_regWrite SHALL clear to 0, and all other wb_* registers SHALL clear to 0.
REQ-022 When flush and stall are both asserted in the same cycle, flush SHALL win.
REQ-023 With BYPASS=1, every wb_* field SHALL equal its mem_* input combinationally, stall SHALL be ignored, and flush SHALL force wb_valid=0 and wb_regWrite=0 combinationally.
REQ-024 wb_write_data SHALL be selected by wb_memToReg as follows: 0 -> wb_alu_out, 1 -> wb_read_data, 2 -> wb_pc_plus, 3 -> wb_sign_ext_low_bits.
REQ-025 wb_reg_we SHALL equal wb_valid AND wb_regWrite, combinationally, in both modes.
REQ-026 retire_cnt SHALL increment by 1 on each rising edge where wb_valid=1, stall=0, and rst=0.
REQ-027 retire_cnt SHALL wrap modulo 2^CNT_W with no saturation and no flag.
REQ-028 In BYPASS=1 mode, retire_cnt SHALL use the same rule, with wb_valid taken as its combinational value.
REQ-029 A stalled valid instruction SHALL be counted exactly once, on the edge at which stall is deasserted.
REQ-030 A flushed instruction SHALL NOT be counted after the flush edge.
REQ-031 The block SHALL contain no other state.
REQ-032 No output SHALL depend combinationally on stall in BYPASS=0 mode.

Reset
REQ-033 On a rising edge with rst=1, all wb_* registers and retire_cnt SHALL become 0, regardless of stall or flush.
REQ-034 Out of reset, the block SHALL therefore present wb_valid=0, wb_reg_we=0 and wb_write_data=0.
REQ-035 Reset asserted mid-stall SHALL discard the held instruction and SHALL NOT count it.
REQ-036 The first load after rst deasserts SHALL behave as a normal load.

Verification
REQ-037 BYPASS=0 load: drive mem_valid=1, regWrite=1, memToReg=1, write_reg=5, read_data=0xBEEF -> the next cycle SHALL show wb_write_reg=5, wb_write_data=0xBEEF, wb_reg_we=1, and retire_cnt=1 one edge later.
REQ-038 Mux sweep: hold alu_out=0x1111, read_data=0x2222, pc_plus=0x3333, sext=0x4444 and step memToReg through 0..3 -> wb_write_data SHALL read 0x1111, 0x2222, 0x3333, 0x4444 on successive cycles.
REQ-039 Stall: load alu_out=0x00AA, then stall for 3 cycles while the inputs change to 0x0055 -> wb_alu_out SHALL stay 0x00AA for 3 cycles, then become 0x0055; retire_cnt SHALL advance by 1 for the 0x00AA instruction, and only at stall release.
REQ-040 Flush with stall: hold a valid regWrite=1 instruction, then assert flush=1 and stall=1 together -> next cycle SHALL show wb_valid=0, wb_reg_we=0 and all fields 0, with retire_cnt unchanged.
REQ-041 Wrap and reset: with CNT_W=4, retire 17 valid instructions -> retire_cnt SHALL equal 1; then assert rst during a stall -> all outputs SHALL be 0 the next cycle.
REQ-042 BYPASS=1: change mem_alu_out to 0x7777 with memToReg=0 and mem_valid=1 -> wb_write_data SHALL equal 0x7777 in the same cycle; asserting flush SHALL drop wb_reg_we to 0 in the same cycle.
